// File: rtl/cic_comb_upsampler.sv
// CIC interpolator front end: N-stage comb at the input rate, then zero-stuffing
// by RATE onto the clk_en output rate, widened to integrator width.
module cic_comb_upsampler #(
  parameter int WIDTH     = 16,
  parameter int GROWTH    = 7,
  parameter int SIGN      = 1,
  parameter int N_STAGES  = 3,
  parameter int RATE      = 16,
  parameter int OUT_WIDTH = WIDTH + GROWTH + SIGN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid,
  output logic                        underrun
);

  localparam int PW = $clog2(RATE);

  logic [PW-1:0]               phase;
  logic                        slot;
  logic signed [OUT_WIDTH-1:0] comb_in;
  logic signed [OUT_WIDTH-1:0] comb_out;

  assign slot     = clk_en && (phase == '0);
  // Gated by reset so the source never sees a transfer while state is held cleared.
  assign in_ready = slot && rst;

  assign comb_in = in_valid ? OUT_WIDTH'(signed'(in_data)) : '0;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic signed [OUT_WIDTH-1:0] stage_in;
    logic signed [OUT_WIDTH-1:0] dly;
    logic signed [OUT_WIDTH-1:0] diff;

    if (k == 0) begin : g_first
      assign stage_in = comb_in;
    end else begin : g_next
      assign stage_in = g_stage[k-1].diff;
    end

    assign diff = stage_in - dly;

    // Delays advance on every slot, including underrun slots, so a missing
    // sample looks like a zero to the rest of the CIC chain.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dly <= '0;
      end else if (slot) begin
        dly <= stage_in;
      end
    end
  end

  assign comb_out = g_stage[N_STAGES-1].diff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (clk_en) begin
        phase     <= (phase == PW'(RATE - 1)) ? '0 : phase + PW'(1);
        out       <= slot ? comb_out : '0;
        out_valid <= 1'b1;
      end else begin
        out       <= '0;
        out_valid <= 1'b0;
      end
      if (slot && !in_valid) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cic_comb_upsampler.md
# cic_comb_upsampler

Front half of the CIC interpolator in the DSM DAC path. Accepts signed PCM samples through a valid/ready handshake at the low rate and runs them through an N-stage comb section (differential delay 1). It then zero-stuffs by RATE and drives the comb result, sign-extended to integrator width, into the integrator chain at the `clk_en` rate. The output width matches the integrator input width, so the output connects directly to the first integrator stage.

## Interface
- WIDTH, 16, input sample width (two's complement)
- GROWTH, 7, bit growth reserved for the CIC chain
- SIGN, 1, extra sign/guard bit
- N_STAGES, 3, number of comb stages (1..8)
- RATE, 16, interpolation factor R (2..256, any integer)
- OUT_WIDTH, WIDTH+GROWTH+SIGN, output and internal comb width
- clk  in  1  system clock; one clock only
- rst  in  1  reset, asynchronous and active-low
- clk_en  in  1  output-rate tick; one output sample per cycle with clk_en=1
- in_data  in  WIDTH  signed input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out  out  OUT_WIDTH  zero-stuffed comb output, signed
- out_valid  out  1  out carries a sample (comb result or stuffed zero)
- underrun  out  1  sticky: an input slot passed with no sample available

## Operation
- Phase counter `phase` in 0..RATE-1 advances by 1 on every clk_en=1 cycle and wraps RATE-1 -> 0. It does not move when clk_en=0.
- Slot cycle: clk_en=1 and phase==0. `in_ready` = slot cycle, combinational from registered phase and clk_en.
- Accept: slot cycle with in_valid=1. The comb input is in_data sign-extended to OUT_WIDTH.
- Underrun: slot cycle with in_valid=0.
  - Comb input is 0. Delay registers still update, so CIC state stays consistent.
  - `underrun` sets to 1 and stays set until reset.
- Comb chain:
  - Stage k computes c[k] = c[k-1] - d[k], where c[0] is the comb input and d[k] is the stage-k delay register.
  - On every slot cycle, d[k] <= c[k-1].
  - The chain is combinational within the slot cycle.
- Arithmetic: all comb math is OUT_WIDTH-bit two's complement with silent modulo wrap. There is no saturation; the downstream integrators rely on the wrap.
- Output register, updated on every clk_en=1 cycle:
  - slot cycle: out <= c[N_STAGES]
  - other phases: out <= 0
  - out_valid <= 1
- Cycles with clk_en=0: out_valid <= 0 and out <= 0. Out is therefore 0 whenever out_valid=0, and a downstream integrator clocked every cycle sees a correctly zero-stuffed stream.
- Source handshake: the source may hold in_valid high indefinitely. A transfer happens only when in_valid and in_ready are both high. in_data must be stable while in_valid=1 and in_ready=0.

## Timing
- Reset (rst=0, asynchronous): phase=0, all d[k]=0, out=0, out_valid=0, underrun=0. in_ready=0 while in reset.
- After reset release, the first clk_en=1 cycle is a slot cycle.
- Latency: a sample accepted in cycle T appears on out, with out_valid=1, in cycle T+1.
- For the RATE-1 ticks after each slot, out=0 with out_valid=1 at each tick+1.
- Throughput: one input per RATE clk_en ticks. With clk_en tied high, in_ready is high 1 cycle in RATE.
- Reset mid-operation: all in-flight state is discarded immediately. No partial output is produced after rst rises.
- clk_en deasserted on a would-be slot cycle: no slot occurs and no underrun. The slot moves to the next clk_en=1 cycle.
- in_valid falling without an accept is legal and has no effect.

## Test plan
- Reset: assert rst=0 mid-stream with nonzero delays -> out=0, out_valid=0, in_ready=0, underrun=0 asynchronously. After release, the first clk_en cycle is a slot.
- Step, N_STAGES=1, RATE=4, clk_en=1, in_data=100 constant -> out sequence 100,0,0,0, then 0 forever (step differentiates to an impulse). in_ready pattern 1,0,0,0 repeating.
- Impulse, N_STAGES=3, RATE=4: input 1 then zeros -> slot outputs 1,-3,3,-1,0 with three zeros between each.
- Wrap, N_STAGES=1, WIDTH=16: inputs -32768 then 32767 -> second slot out=65535, no saturation. With OUT_WIDTH forced to 16, it wraps to -1.
- Underrun: withhold in_valid on the 3rd slot -> that slot's comb input is 0, underrun=1 from the next cycle and stays 1. Later accepts continue normally.
- Sparse clk_en (every 3rd cycle), RATE=2: in_ready and out_valid are high only on clk_en cycles (+1 for out_valid). out=0 on all other cycles. Total accepted samples = ticks/2.
